// File: rtl/seq_pkg.sv
// Shared definitions for the serial feeder and the sequence detector benches.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  // Counter widths must never collapse to zero bits.
  function automatic int min1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down counter that holds at zero; used for bit and gap timing.
module frame_down_counter #(
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          zero
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/serial_bit_feeder.sv
// Serialises handshaked parallel words onto a registered 1-bit stream with
// a programmable idle gap between frames.
module serial_bit_feeder
  import seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 2,
  parameter bit IDLE_BIT   = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = min1($clog2(GAP_CYCLES + 1));
  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic             x_reg, x_next;
  logic             x_valid_reg, x_valid_next;
  logic             frame_done_reg, frame_done_next;

  logic          bit_load, bit_en, bit_zero;
  logic [BW-1:0] bit_cnt;
  logic          gap_load, gap_en, gap_zero;
  logic [GW-1:0] gap_cnt;

  frame_down_counter #(.CW(BW)) u_bit_cnt (
    .clock      (clock),
    .reset      (reset),
    .load       (bit_load),
    .load_value (BIT_LOAD),
    .enable     (bit_en),
    .count      (bit_cnt),
    .zero       (bit_zero)
  );

  frame_down_counter #(.CW(GW)) u_gap_cnt (
    .clock      (clock),
    .reset      (reset),
    .load       (gap_load),
    .load_value (GAP_LOAD),
    .enable     (gap_en),
    .count      (gap_cnt),
    .zero       (gap_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      shreg_reg      <= '0;
      x_reg          <= IDLE_BIT;
      x_valid_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shreg_reg      <= shreg_next;
      x_reg          <= x_next;
      x_valid_reg    <= x_valid_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    shreg_next      = shreg_reg;
    x_next          = IDLE_BIT;
    x_valid_next    = 1'b0;
    frame_done_next = 1'b0;
    bit_load        = 1'b0;
    bit_en          = 1'b0;
    gap_load        = 1'b0;
    gap_en          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (load_valid) begin
          state_next      = ST_SHIFT;
          x_next          = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
          x_valid_next    = 1'b1;
          frame_done_next = (WIDTH == 1);
          shreg_next      = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
          bit_load        = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (bit_zero) begin
          // Last bit has been shown; fall back to idle level immediately.
          if (GAP_CYCLES > 0) begin
            state_next = ST_GAP;
            gap_load   = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          x_next          = MSB_FIRST ? shreg_reg[WIDTH-1] : shreg_reg[0];
          x_valid_next    = 1'b1;
          shreg_next      = MSB_FIRST ? (shreg_reg << 1) : (shreg_reg >> 1);
          bit_en          = 1'b1;
          frame_done_next = (bit_cnt == BW'(1));
        end
      end
      ST_GAP: begin
        if (gap_zero) begin
          state_next = ST_IDLE;
        end else begin
          gap_en = (gap_cnt != '0);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign load_ready = (state_reg == ST_IDLE);
  assign busy       = (state_reg != ST_IDLE);
  assign x          = x_reg;
  assign x_valid    = x_valid_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Randomised bench for two feeder configurations against a queue-based
// model of the expected per-cycle output stream.
module tb_serial_bit_feeder;

  typedef struct packed {
    logic x;
    logic v;
    logic fd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst [2];
  logic       lv  [2];
  logic [7:0] ld  [2];
  logic       rdy [2];
  logic       xo  [2];
  logic       xv  [2];
  logic       bsy [2];
  logic       fd  [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2), .IDLE_BIT(1'b0)) dut_a (
    .clock      (clk),
    .reset      (rst[0]),
    .load_data  (ld[0]),
    .load_valid (lv[0]),
    .load_ready (rdy[0]),
    .x          (xo[0]),
    .x_valid    (xv[0]),
    .busy       (bsy[0]),
    .frame_done (fd[0])
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_BIT(1'b1)) dut_b (
    .clock      (clk),
    .reset      (rst[1]),
    .load_data  (ld[1]),
    .load_valid (lv[1]),
    .load_ready (rdy[1]),
    .x          (xo[1]),
    .x_valid    (xv[1]),
    .busy       (bsy[1]),
    .frame_done (fd[1])
  );

  task automatic chk(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d t=%0t: got %0h expected %0h", name, ch, $time, act, exp);
    end
  endtask

  task automatic check_cycle(input int ch, input exp_t e, input bit idle_state, input string tag);
    chk({tag, "_x"},     ch, 32'(xo[ch]),  32'(e.x));
    chk({tag, "_xv"},    ch, 32'(xv[ch]),  32'(e.v));
    chk({tag, "_fd"},    ch, 32'(fd[ch]),  32'(e.fd));
    chk({tag, "_ready"}, ch, 32'(rdy[ch]), 32'(idle_state));
    chk({tag, "_busy"},  ch, 32'(bsy[ch]), 32'(!idle_state));
  endtask

  task automatic run(input int ch, input int ncyc);
    exp_t       q[$];
    exp_t       cur;
    exp_t       idle_e;
    logic [7:0] dir[$];
    logic [7:0] lit[$];
    logic [7:0] cap = 8'h00;
    bit         msb = (ch == 0);
    int         gap = (ch == 0) ? 2 : 0;
    logic       idle = (ch == 0) ? 1'b0 : 1'b1;
    bit         held = 1'b0;
    bit         did_rst = 1'b0;
    bit         was_idle;
    int         nacc = 0;
    int         nfd = 0;

    idle_e = '{x: idle, v: 1'b0, fd: 1'b0};
    if (ch == 0) begin
      dir = '{8'h66, 8'hFF, 8'h3C, 8'h81};
      lit = '{8'h66, 8'hFF, 8'h81};
    end else begin
      dir = '{8'hA5, 8'h66, 8'h66};
      lit = '{8'hA5, 8'h66, 8'h66};
    end

    // Reset held across edges while a word is offered: reset must win.
    rst[ch] = 1'b1;
    ld[ch]  = dir[0];
    lv[ch]  = 1'b1;
    held    = 1'b1;
    repeat (2) @(negedge clk);
    check_cycle(ch, idle_e, 1'b1, "reset");
    rst[ch] = 1'b0;

    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge clk);
      cur = (q.size() != 0) ? q[0] : idle_e;
      check_cycle(ch, cur, q.size() == 0, "cycle");

      if (xv[ch] === 1'b1) cap = {cap[6:0], xo[ch]};
      if (fd[ch] === 1'b1) begin
        if (nfd < lit.size()) chk("frame_bits", ch, 32'(cap), 32'(lit[nfd]));
        nfd++;
      end

      // Mid-cycle async reset: once during bit 4 of 8'h3C, then randomly.
      if ((ch == 0 && nacc == 3 && !did_rst && q.size() == 5 + gap) ||
          (nacc > dir.size() + 1 && q.size() != 0 && $urandom_range(0, 199) == 0)) begin
        #2 rst[ch] = 1'b1;
        #1 check_cycle(ch, idle_e, 1'b1, "async_rst");
        $display("ch%0d async reset at t=%0t, %0d entries discarded", ch, $time, q.size());
        q.delete();
        if (ch == 0 && nacc == 3) did_rst = 1'b1;
        @(posedge clk);
        #1 rst[ch] = 1'b0;
        continue;
      end

      was_idle = (q.size() == 0);
      if (!was_idle) void'(q.pop_front());

      if (!held) begin
        if (nacc < dir.size() || $urandom_range(0, 2) != 0) begin
          held   = 1'b1;
          ld[ch] = (nacc < dir.size()) ? dir[nacc] : 8'($urandom);
        end else begin
          ld[ch] = 8'($urandom);
        end
      end
      lv[ch] = held;

      if (was_idle && held) begin
        for (int i = 0; i < 8; i++)
          q.push_back('{x: msb ? ld[ch][7-i] : ld[ch][i], v: 1'b1, fd: (i == 7)});
        for (int g = 0; g < gap; g++) q.push_back(idle_e);
        held = 1'b0;
        nacc++;
        $display("ch%0d accept #%0d data=%02h at t=%0t", ch, nacc, ld[ch], $time);
      end
    end

    chk("frames_seen", ch, 32'(nfd >= lit.size()), 32'd1);
    if (ch == 0) chk("directed_reset_done", ch, 32'(did_rst), 32'd1);
    lv[ch] = 1'b0;
  endtask

  initial begin
    fork
      run(0, 3000);
      run(1, 3000);
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
